// File: rtl/vlc_ac_scan_if.sv
// Handshake bundle between the AC scan sequencer, the coefficient buffer,
// the run/level encoders and the slice controller.
interface vlc_ac_scan_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic [3:0]        num_blocks;
    logic              stall;
    logic              coeff_rd_en;
    logic [ADDR_W-1:0] coeff_rd_addr;
    logic [31:0]       coeff_rd_data;
    logic              enc_input_enable;
    logic [31:0]       enc_coeff;
    logic              run_valid;
    logic              level_valid;
    logic              busy;
    logic              done;
    logic [9:0]        nz_count;
    logic              cfg_err;
    logic              timeout_err;

    modport master (
        output start, num_blocks, stall, coeff_rd_data, run_valid, level_valid,
        input  coeff_rd_en, coeff_rd_addr, enc_input_enable, enc_coeff,
               busy, done, nz_count, cfg_err, timeout_err
    );

    modport slave (
        input  start, num_blocks, stall, coeff_rd_data, run_valid, level_valid,
        output coeff_rd_en, coeff_rd_addr, enc_input_enable, enc_coeff,
               busy, done, nz_count, cfg_err, timeout_err
    );
endinterface

// File: rtl/vlc_ac_scan_sequencer.sv
// Reads one slice of coefficients in AC interleave order (index outer, block inner),
// feeds the run/level encoders and waits for every nonzero result before done.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing buffer reads, one per unstalled cycle
// DRAIN | last data issued, waiting for encoder results or timeout
// DONE  | one-cycle completion pulse
module vlc_ac_scan_sequencer #(
    parameter int MAX_BLOCKS    = 8,
    parameter int ADDR_W        = 9,
    parameter int DRAIN_TIMEOUT = 64
) (
    input logic          clk,
    input logic          reset_n,
    vlc_ac_scan_if.slave bus
);
    localparam int BLK_W = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
    localparam int TO_W  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BLK_W-1:0]  blk;
    logic [BLK_W-1:0]  last_blk;
    logic [BLK_W-1:0]  last_blk_in;
    logic [5:0]        idx;
    logic              empty_slice;
    logic              issue_q;
    logic [6:0]        pend_run;
    logic [6:0]        pend_lvl;
    logic [6:0]        pend_run_nxt;
    logic [6:0]        pend_lvl_nxt;
    logic [9:0]        nz_count;
    logic              cfg_err;
    logic              timeout_err;
    logic [TO_W-1:0]   drain_cnt;
    logic              start_acc;
    logic              over_max;
    logic              rd_en;
    logic              last_rd;
    logic              nz_issue;
    logic              run_spur;
    logic              lvl_spur;
    logic              drain_clear;
    logic              drain_expire;

    function automatic logic [6:0] pend_next(input logic [6:0] cur,
                                             input logic inc, input logic dec);
        logic [6:0] res;
        res = cur;
        if (inc && !dec)
            res = cur + 7'd1;
        else if (dec && !inc && cur != 7'd0)
            res = cur - 7'd1;
        return res;
    endfunction

    always_comb begin
        start_acc    = (state == IDLE) && bus.start;
        over_max     = int'(bus.num_blocks) > MAX_BLOCKS;
        last_blk_in  = over_max ? BLK_W'(MAX_BLOCKS - 1) : BLK_W'(bus.num_blocks - 4'd1);
        rd_en        = (state == ISSUE) && !bus.stall && !empty_slice;
        last_rd      = rd_en && (idx == 6'd63) && (blk == last_blk);
        nz_issue     = issue_q && (bus.coeff_rd_data != 32'd0);
        run_spur     = bus.run_valid && !nz_issue && (pend_run == 7'd0);
        lvl_spur     = bus.level_valid && !nz_issue && (pend_lvl == 7'd0);
        pend_run_nxt = pend_next(pend_run, nz_issue, bus.run_valid);
        pend_lvl_nxt = pend_next(pend_lvl, nz_issue, bus.level_valid);
        // Looks one cycle ahead so a zero final coefficient finishes without an extra DRAIN cycle.
        drain_clear  = (pend_run_nxt == 7'd0) && (pend_lvl_nxt == 7'd0);
        drain_expire = (state == DRAIN) && !drain_clear && (drain_cnt == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                if (empty_slice)
                    state_nxt = DONE;
                else if (last_rd)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_clear || drain_expire)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk         <= '0;
            last_blk    <= '0;
            idx         <= 6'd0;
            empty_slice <= 1'b0;
            issue_q     <= 1'b0;
            pend_run    <= 7'd0;
            pend_lvl    <= 7'd0;
            nz_count    <= 10'd0;
            cfg_err     <= 1'b0;
            timeout_err <= 1'b0;
            drain_cnt   <= '0;
        end else begin
            issue_q <= rd_en;
            if (start_acc) begin
                blk         <= '0;
                idx         <= 6'd1;
                last_blk    <= last_blk_in;
                empty_slice <= (bus.num_blocks == 4'd0);
                cfg_err     <= (bus.num_blocks == 4'd0) || over_max;
                timeout_err <= 1'b0;
                nz_count    <= 10'd0;
                pend_run    <= 7'd0;
                pend_lvl    <= 7'd0;
            end else begin
                if (rd_en) begin
                    if (blk == last_blk) begin
                        blk <= '0;
                        idx <= idx + 6'd1;
                    end else begin
                        blk <= blk + BLK_W'(1);
                    end
                end
                if (nz_issue)
                    nz_count <= nz_count + 10'd1;
                if (drain_expire) begin
                    pend_run    <= 7'd0;
                    pend_lvl    <= 7'd0;
                    timeout_err <= 1'b1;
                end else begin
                    pend_run <= pend_run_nxt;
                    pend_lvl <= pend_lvl_nxt;
                    if (run_spur || lvl_spur)
                        timeout_err <= 1'b1;
                end
            end
            if (last_rd)
                drain_cnt <= TO_W'(DRAIN_TIMEOUT - 1);
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - TO_W'(1);
        end
    end

    assign bus.coeff_rd_en      = rd_en;
    assign bus.coeff_rd_addr    = ADDR_W'({blk, idx});
    assign bus.enc_input_enable = issue_q;
    assign bus.enc_coeff        = issue_q ? bus.coeff_rd_data : 32'd0;
    assign bus.busy             = (state != IDLE);
    assign bus.done             = (state == DONE);
    assign bus.nz_count         = nz_count;
    assign bus.cfg_err          = cfg_err;
    assign bus.timeout_err      = timeout_err;
endmodule

// File: tb/tb_vlc_ac_scan_sequencer.sv
// Scoreboard bench for the AC scan sequencer: buffer and encoder models,
// expected read addresses and issued data queued and compared as the DUT produces them.
module tb_vlc_ac_scan_sequencer;
    localparam int MAX_BLOCKS    = 8;
    localparam int ADDR_W        = 9;
    localparam int DRAIN_TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    vlc_ac_scan_if #(.ADDR_W(ADDR_W)) bus ();

    vlc_ac_scan_sequencer #(
        .MAX_BLOCKS   (MAX_BLOCKS),
        .ADDR_W       (ADDR_W),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int enc_cnt = 0;
    int enc_lat = 5;
    bit drop_lvl = 1'b0;
    int stall_left = 0;

    logic [31:0]       mem [512];
    logic [ADDR_W-1:0] addr_q [$];
    logic [31:0]       data_q [$];
    int                run_t [$];
    int                lvl_t [$];
    int                stall_pts [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        bus.coeff_rd_data <= bus.coeff_rd_en ? mem[bus.coeff_rd_addr] : 32'hDEAD_BEEF;

    // Encoder result and backpressure driver, updated just after each edge.
    always @(posedge clk) begin
        #1;
        bus.run_valid = 1'b0;
        bus.level_valid = 1'b0;
        if (run_t.size() > 0) begin
            if (run_t[0] == cyc) begin
                bus.run_valid = 1'b1;
                void'(run_t.pop_front());
            end
        end
        if (lvl_t.size() > 0) begin
            if (lvl_t[0] == cyc) begin
                bus.level_valid = 1'b1;
                void'(lvl_t.pop_front());
            end
        end
        if (stall_left > 0) begin
            bus.stall = 1'b1;
            stall_left--;
        end else if (stall_pts.size() > 0 && rd_cnt == stall_pts[0]) begin
            void'(stall_pts.pop_front());
            bus.stall = 1'b1;
            stall_left = 2;
        end else begin
            bus.stall = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [ADDR_W-1:0] a;
        if (reset_n) begin
            if (bus.stall)
                chk("no_read_while_stalled", bus.coeff_rd_en, 0);
            if (bus.coeff_rd_en) begin
                rd_cnt++;
                if (addr_q.size() == 0)
                    chk("extra_read", addr_q.size(), 1);
                else begin
                    a = addr_q.pop_front();
                    chk("read_addr", bus.coeff_rd_addr, a);
                    data_q.push_back(mem[a]);
                end
            end
            if (bus.enc_input_enable) begin
                enc_cnt++;
                if (data_q.size() == 0)
                    chk("extra_issue", data_q.size(), 1);
                else
                    chk("enc_coeff", bus.enc_coeff, data_q.pop_front());
                if (bus.enc_coeff != 32'd0) begin
                    run_t.push_back(cyc + enc_lat);
                    if (drop_lvl)
                        drop_lvl = 1'b0;
                    else
                        lvl_t.push_back(cyc + enc_lat);
                end
            end else if (bus.enc_coeff != 32'd0) begin
                chk("enc_coeff_idle_zero", bus.enc_coeff, 0);
            end
        end
    end

    task automatic push_expected(input int nb);
        int neff;
        neff = (nb > MAX_BLOCKS) ? MAX_BLOCKS : nb;
        for (int i = 1; i < 64; i++)
            for (int b = 0; b < neff; b++)
                addr_q.push_back(ADDR_W'(b * 64 + i));
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 512; i++)
            mem[i] = rnd ? (($urandom_range(0, 2) == 0) ? 32'd0 : $urandom) : 32'd0;
    endtask

    task automatic run_slice(input string tag, input int nb, input int lat_exp,
                             input int reads_exp, input int nz_exp, input bit cfg_exp,
                             input bit to_exp, input bit restart);
        int s;
        bit seen;
        push_expected(nb);
        rd_cnt = 0;
        enc_cnt = 0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.num_blocks = 4'(nb);
        s = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (bus.done)
                seen = 1'b1;
            if (restart && i == 30) begin
                bus.start = 1'b1;
                bus.num_blocks = 4'd1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            chk({tag, "_done_latency"}, cyc - s, lat_exp);
            chk({tag, "_busy_at_done"}, bus.busy, 1);
            chk({tag, "_reads"}, rd_cnt, reads_exp);
            chk({tag, "_issues"}, enc_cnt, reads_exp);
            chk({tag, "_reads_left"}, addr_q.size(), 0);
            chk({tag, "_nz_count"}, bus.nz_count, nz_exp);
            chk({tag, "_cfg_err"}, bus.cfg_err, cfg_exp);
            chk({tag, "_timeout_err"}, bus.timeout_err, to_exp);
            @(negedge clk);
            chk({tag, "_done_one_cycle"}, bus.done, 0);
            chk({tag, "_idle_after"}, bus.busy, 0);
            chk({tag, "_nz_held"}, bus.nz_count, nz_exp);
        end
        addr_q.delete();
        data_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        bus.start = 1'b0;
        bus.num_blocks = 4'd0;
        fill_mem(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_rd_en", bus.coeff_rd_en, 0);
        chk("reset_enc_en", bus.enc_input_enable, 0);
        chk("reset_nz_count", bus.nz_count, 0);
        chk("reset_cfg_err", bus.cfg_err, 0);
        chk("reset_timeout_err", bus.timeout_err, 0);
        reset_n = 1'b1;

        enc_lat = 5;
        run_slice("all_zero_n1", 1, 65, 63, 0, 0, 0, 0);

        fill_mem(1'b0);
        mem[1] = 32'h0000_0011;
        mem[66] = 32'hFFFF_FFFB;
        mem[127] = 32'd7;
        run_slice("two_blocks", 2, 133, 126, 3, 0, 0, 1);

        fill_mem(1'b1);
        mem[255] = 32'h0000_1234;
        nz = 0;
        for (int b = 0; b < 4; b++)
            for (int i = 1; i < 64; i++)
                if (mem[b * 64 + i] != 32'd0) nz++;
        stall_pts.push_back(9);
        stall_pts.push_back(251);
        run_slice("stall_n4", 4, 265, 252, nz, 0, 0, 0);

        fill_mem(1'b0);
        mem[62] = 32'd3;
        mem[63] = 32'd9;
        enc_lat = 1;
        run_slice("inc_dec_same_cycle", 1, 66, 63, 2, 0, 0, 0);

        enc_lat = 5;
        fill_mem(1'b0);
        run_slice("zero_blocks", 0, 2, 0, 0, 1, 0, 0);
        run_slice("clamp_12", 12, 506, 504, 0, 1, 0, 0);

        mem[1] = 32'd5;
        drop_lvl = 1'b1;
        run_slice("drain_timeout", 1, 64 + DRAIN_TIMEOUT, 63, 1, 0, 1, 0);
        chk("timeout_level_queue_empty", lvl_t.size(), 0);

        for (int i = 0; i < 512; i++)
            mem[i] = $urandom | 32'd1;
        push_expected(12);
        rd_cnt = 0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.num_blocks = 4'd12;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy_before_reset", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_rd_en", bus.coeff_rd_en, 0);
        chk("mid_reset_enc_en", bus.enc_input_enable, 0);
        chk("mid_reset_enc_coeff", bus.enc_coeff, 0);
        chk("mid_reset_busy", bus.busy, 0);
        chk("mid_reset_nz_count", bus.nz_count, 0);
        chk("mid_reset_cfg_err", bus.cfg_err, 0);
        chk("mid_reset_done", bus.done, 0);
        addr_q.delete();
        data_q.delete();
        run_t.delete();
        lvl_t.delete();
        repeat (2) begin
            @(negedge clk);
            chk("no_done_in_reset", bus.done, 0);
        end
        reset_n = 1'b1;
        fill_mem(1'b0);
        run_slice("after_reset", 1, 65, 63, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vlc_ac_scan_sequencer.md
Name: vlc_ac_scan_sequencer

Overview:
Sequences one slice of quantized coefficients into the AC run and AC level entropy encoders. The slice is read from the coefficient buffer in ProRes AC interleave order: for each index 1..63, then for each block 0..N-1. The block drives input_enable and Coeff, counts the nonzero coefficients it issues, and waits until both encoders have returned one result per nonzero coefficient before it signals slice done. It sits between the coefficient buffer and the run/level encoders, under the slice controller.

Parameters:
MAX_BLOCKS, 8, maximum blocks per slice (power of 2).
ADDR_W, 9, coefficient buffer address width; must be at least log2(MAX_BLOCKS*64).
DRAIN_TIMEOUT, 64, number of cycles allowed in DRAIN before the block flags a timeout.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins a slice; sampled only in IDLE
num_blocks  in  4  blocks in the slice; latched on start
stall  in  1  downstream packer backpressure; blocks new reads while high
coeff_rd_en  out  1  coefficient buffer read strobe
coeff_rd_addr  out  ADDR_W  read address = block*64 + index
coeff_rd_data  in  32  read data, valid exactly 1 cycle after coeff_rd_en
enc_input_enable  out  1  to run and level encoders (input_enable)
enc_coeff  out  32  to run and level encoders (Coeff)
run_valid  in  1  run encoder output valid
level_valid  in  1  level encoder output valid
busy  out  1  high from the cycle after start until the done cycle, inclusive
done  out  1  one-cycle pulse at slice completion
nz_count  out  10  nonzero coefficients issued in the current or last slice
cfg_err  out  1  sticky; cleared on the next accepted start
timeout_err  out  1  sticky; cleared on the next accepted start

Behaviour:
- Reset: state IDLE; all outputs 0; all counters 0.
- States: IDLE -> ISSUE on start.
  - num_blocks==0: go to DONE directly, no reads issued, set cfg_err.
  - num_blocks>MAX_BLOCKS: clamp to MAX_BLOCKS, set cfg_err.
  - ISSUE -> DRAIN after the final read, idx=63 and blk=N-1.
  - DRAIN -> DONE when the last read's data has been issued and pend_run==0 and pend_lvl==0.
  - DONE -> IDLE after 1 cycle. done=1 and busy=1 in DONE.
- Counters: blk (3b) is the inner counter and runs 0..N-1. idx (6b) is the outer counter and runs 1..63. Both are held while stall=1.
- Read issue: in ISSUE with stall=0, coeff_rd_en=1 on each cycle with the current address. With stall=1, coeff_rd_en=0 and no counter advances.
- Issue path: enc_input_enable is coeff_rd_en delayed 1 cycle. enc_coeff = coeff_rd_data on that same cycle. A read already in flight when stall rises is still issued (the encoders have no backpressure). When enc_input_enable=0, enc_coeff is held at 0.
- Totals: exactly 63*N reads and 63*N enc_input_enable pulses per slice, with zero gaps when stall stays low. Issue latency is 1 cycle from start to the first coeff_rd_en, and 2 cycles from start to the first enc_input_enable.
- Pending counters (7b each):
  - pend_run increments on enc_input_enable && enc_coeff!=0 and decrements on run_valid.
  - pend_lvl works the same way using level_valid.
  - If increment and decrement occur in the same cycle, the count is unchanged.
  - A decrement at 0 is ignored and sets timeout_err (spurious output).
- nz_count increments with each pend increment, is reset on an accepted start, and holds after done.
- Trailing zeros produce no encoder output and are not counted.
- Timeout: a DRAIN cycle counter counts up to DRAIN_TIMEOUT. On expiry: set timeout_err, force DONE, clear pend counters.
- start while busy is ignored.
- Reset mid-slice: everything returns immediately to the reset values, and no done pulse is generated.

Test Plan:
- N=1, all coefficients zero, stall=0 -> 63 reads at addresses 1..63, 63 enc_input_enable pulses, nz_count=0, done 65 cycles after start, no errors.
- N=2, nonzero at addresses 1, 66, 127, encoder model returning valids 5 cycles later -> read order 1, 65, 2, 66, ..., 63, 127; nz_count=3; done only after the third run_valid and the third level_valid.
- N=4 random data with stall high for 3 cycles at read #10 and at the final read -> no coeff_rd_en while stalled; the in-flight read is still issued; 252 total issues; addresses contiguous in interleave order.
- Simultaneous enc_input_enable with nonzero data and run_valid while pend_run=1 -> pend_run stays 1; done is delayed until the next run_valid.
- num_blocks=0 -> cfg_err=1, no reads, done 2 cycles after start. num_blocks=12 -> cfg_err=1, 504 reads issued.
- Encoder model drops one level_valid -> timeout_err=1, done asserted DRAIN_TIMEOUT cycles into DRAIN. Separately, assert reset_n mid-ISSUE -> all outputs 0 immediately, and a following start runs the slice cleanly.
